// File: rtl/imem_responder.sv
// Instruction-memory responder: word-organised fetch memory with fixed-latency,
// backpressured responses and a side load port for filling the array.
`timescale 1ns/1ps
module imem_responder #(
   parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic [31:0]                    req_addr,
   output logic                           resp_valid,
   input  logic                           resp_ready,
   output logic [31:0]                    resp_inst,
   output logic                           resp_err,
   input  logic                           ld_en,
   input  logic [$clog2(DEPTH_WORDS)-1:0] ld_idx,
   input  logic [31:0]                    ld_data
);

   localparam int          IDX_W     = $clog2(DEPTH_WORDS);
   localparam logic [31:0] MEM_BYTES = 32'(DEPTH_WORDS) << 2;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t             state_q;
   logic [3:0]         cnt_q;
   logic [IDX_W-1:0]   idx_q;
   logic               err_q;
   logic               resp_valid_q;
   logic [31:0]        resp_inst_q;
   logic               resp_err_q;

   logic [31:0]        offset;
   logic               err_d;
   logic [IDX_W-1:0]   idx_d;
   logic               enter_resp;
   logic               rd_err;
   logic [IDX_W-1:0]   rd_idx;

   logic [31:0]        mem [DEPTH_WORDS];

   // Below-base is tested on the raw address, so a wrapped offset never looks in range.
   always_comb begin
      offset     = req_addr - ADDR_BASE;
      err_d      = (req_addr[1:0] != 2'b00) || (req_addr < ADDR_BASE) || (offset >= MEM_BYTES);
      idx_d      = offset[IDX_W+1:2];
      enter_resp = ((state_q == IDLE) && req_valid && (LATENCY == 1)) ||
                   ((state_q == WAIT) && (cnt_q == 4'd1));
      rd_err     = (state_q == IDLE) ? err_d : err_q;
      rd_idx     = (state_q == IDLE) ? idx_d : idx_q;
   end

   // NOTE: the array has no reset branch, so contents survive rst and map to plain RAM.
   always_ff @(posedge clk) begin
      if (ld_en && !rst) begin
         mem[ld_idx] <= ld_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         err_q        <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_inst_q  <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  idx_q   <= idx_d;
                  err_q   <= err_d;
                  cnt_q   <= 4'(LATENCY - 1);
                  state_q <= (LATENCY > 1) ? WAIT : RESP;
               end
            end
            WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_q <= RESP;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  state_q      <= IDLE;
                  resp_valid_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase

         // NOTE: non-blocking read returns the pre-edge word, so a same-edge load is not seen.
         if (enter_resp) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= rd_err;
            resp_inst_q  <= rd_err ? '0 : mem[rd_idx];
         end
      end
   end

   assign req_ready  = (state_q == IDLE) && !rst;
   assign resp_valid = resp_valid_q;
   assign resp_inst  = resp_inst_q;
   assign resp_err   = resp_err_q;

endmodule
